tinyalu_rtl: RTL
================

Name: tinyalu_rtl

Overview:
Synthesizable TinyALU core that executes one command per start/done handshake on the pin-level ALU interface. It returns results to the requester, which is the TLM driver/monitor side of the bench. It is the RTL counterpart that the TLM predictor's results are compared against. Single clock domain; it sits directly under the DUT top.

Parameters:
DATA_W, 8, operand width; result width is 2*DATA_W.
MUL_LATENCY, 3, cycles from operand-sampling edge to done for mul_op; legal range 2..8.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous active-low reset, sampled on rising clk
start  input  1  request valid; held by requester until done
op  input  3  opcode: no_op=000, add_op=001, and_op=010, xor_op=011, mul_op=100, rst_op=111; 101/110 illegal
A  input  DATA_W  operand A
B  input  DATA_W  operand B
busy  output  1  high while a command is in flight (EXEC state)
done  output  1  one-cycle pulse when result is valid
result  output  2*DATA_W  last computed result, held between commands

Behaviour:
- Interface contract: clock is clk; reset is reset_n, synchronous and active-low. No asynchronous reset anywhere.
- Reset values: busy=0, done=0, result=0, state=IDLE, latency counter=0, multiplier pipe regs=0.
- FSM states are IDLE, EXEC and DONE.
- IDLE:
  - start=1 at edge E0 captures A, B and op.
  - add/and/xor: go to DONE at E0. result and done are registered at E1, so latency is 1.
  - mul: go to EXEC with counter=1.
  - no_op: stay IDLE, no done, result unchanged.
  - rst_op: result<=0 at E0, stay IDLE, no done.
- EXEC (mul only):
  - busy=1; counter increments each edge.
  - Product flows through MUL_LATENCY-1 register stages.
  - When counter==MUL_LATENCY-1, move to DONE. result=A*B and done=1 both appear after edge E(MUL_LATENCY).
- DONE:
  - done=1 for exactly one cycle. start and op are ignored in this cycle.
  - Unconditionally return to IDLE at the next edge.
- Back-to-back: if the requester keeps start high after done, the next command is sampled at E(L+1), where L is the latency of the previous op. Minimum spacing is L+1 cycles.
- Arithmetic:
  - add: zero-extended DATA_W+1-bit sum; upper bits are 0.
  - and/xor: bitwise A&B / A^B, upper DATA_W bits 0.
  - mul: full 2*DATA_W unsigned product. No truncation or saturation.
- Operand and op changes while busy=1 have no effect; captured values are used.
- reset_n=0 at any edge, including mid-EXEC or in DONE:
  - All state returns to reset values at that edge.
  - An in-flight mul is discarded and no done is issued for it.
- Illegal opcodes: behaviour is set by the optional feature below.

Optional Feature:
- Macro: TINYALU_ERR_EN.
- Defined: adds output port err (1 bit, reset 0).
  - Illegal opcode sampled in IDLE with start=1 goes to DONE.
  - At E1: err=1 and done=1 for one cycle; result is unchanged.
  - err is 0 in all other cycles.
- Undefined: no err port. Illegal opcodes are treated exactly as no_op: stay IDLE, no done, result unchanged.

Test Plan:
1. add A=0xFF B=0xFF start at E0 -> done=1 and result=0x01FE in the cycle after E1; busy never 1.
2. mul A=0xFF B=0xFF, MUL_LATENCY=3 -> busy=1 after E0 until E3; done=1 and result=0xFE01 after E3; done low at E4.
3. xor A=0xA5 B=0x0F, then and A=0xA5 B=0x0F with start held high -> result=0x00AA, done at E1; next command sampled at E2; result=0x0005, done at E3.
4. add 0x01+0x02 (result 0x0003), then rst_op -> result=0x0000 after sampling edge; no done pulse; then no_op -> no done, result stays 0.
5. mul 0x10*0x10 with reset_n=0 at E2 -> at E3 busy=0, done=0, result=0; no done ever appears for that mul.
6. op=101 start at E0 -> with TINYALU_ERR_EN: err=1 and done=1 after E1, result unchanged. Without it: no done, stays IDLE, result unchanged.

Source files
------------

// File: rtl/tinyalu_rtl.sv
// rtl/tinyalu_rtl.sv - TinyALU core: one command per start/done handshake, pipelined multiply
// Optional illegal-opcode error reporting when TINYALU_ERR_EN is defined.
module tinyalu_rtl #(
    parameter int DATA_W      = 8,
    parameter int MUL_LATENCY = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [2:0]          op,
    input  logic [DATA_W-1:0]   A,
    input  logic [DATA_W-1:0]   B,
    output logic                busy,
    output logic                done,
`ifdef TINYALU_ERR_EN
    output logic                err,
`endif
    output logic [2*DATA_W-1:0] result
);

    localparam int RES_W  = 2 * DATA_W;
    localparam int CNT_W  = 4;
    localparam int STAGES = MUL_LATENCY - 1;

    localparam logic [2:0] OP_NO  = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_RST = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  b_q;
    logic [2:0]         op_q;
    logic [RES_W-1:0]   pipe [STAGES];

    function automatic logic is_single(input logic [2:0] o);
        return (o == OP_ADD) || (o == OP_AND) || (o == OP_XOR);
    endfunction

    function automatic logic is_illegal(input logic [2:0] o);
        return (o == 3'b101) || (o == 3'b110);
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (is_single(op)) begin
                        state_nxt = S_DONE;
                    end else if (op == OP_MUL) begin
                        state_nxt = S_EXEC;
                    end
`ifdef TINYALU_ERR_EN
                    else if (is_illegal(op)) begin
                        state_nxt = S_DONE;
                    end
`endif
                end
            end
            S_EXEC: begin
                if (cnt == CNT_W'(MUL_LATENCY - 1)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operands are captured once in IDLE so requester changes during EXEC are ignored.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= OP_NO;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
`ifdef TINYALU_ERR_EN
            err    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef TINYALU_ERR_EN
            err  <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q  <= A;
                        b_q  <= B;
                        op_q <= op;
                        if (op == OP_RST) begin
                            result <= '0;
                        end
                        if (op == OP_MUL) begin
                            cnt  <= CNT_W'(1);
                            busy <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    cnt <= cnt + CNT_W'(1);
                end
                S_DONE: begin
                    done <= 1'b1;
                    case (op_q)
                        OP_ADD: result <= RES_W'(a_q) + RES_W'(b_q);
                        OP_AND: result <= RES_W'(a_q & b_q);
                        OP_XOR: result <= RES_W'(a_q ^ b_q);
                        OP_MUL: begin
                            result <= pipe[STAGES-1];
                            busy   <= 1'b0;
                            cnt    <= '0;
                        end
                        default: begin
`ifdef TINYALU_ERR_EN
                            err <= is_illegal(op_q);
`endif
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Free-running product pipe; the last stage is valid when the FSM reaches DONE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < STAGES; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= RES_W'(a_q) * RES_W'(b_q);
            for (int i = 1; i < STAGES; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

endmodule
